// File: rtl/instruction_loader.sv
// instruction_loader: assembles UART bytes (MSB first) into instruction words
// and writes them to consecutive instruction-memory addresses until a HALT word
// has been written or the memory is full.
module instruction_loader #(
   parameter int                 NB_DATA   = 32,
   parameter int                 N_BITS    = 8,
   parameter int                 NB_ADDR   = 7,
   parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFC000000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_start_i,
   input  logic [N_BITS-1:0]  rx_data_i,
   input  logic               rx_done_tick_i,
   output logic               wr_en_o,
   output logic [NB_ADDR-1:0] wr_addr_o,
   output logic [NB_DATA-1:0] wr_data_o,
   output logic               busy_o,
   output logic               load_done_o,
   output logic               overflow_o,
   output logic [NB_ADDR:0]   word_count_o
);

   localparam int BYTES = NB_DATA / N_BITS;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [BCW-1:0]     byte_cnt;
   logic [NB_ADDR-1:0] addr_cnt;
   logic [NB_DATA-1:0] shift_reg;

   logic               start;
   logic               byte_take;
   logic               word_done;
   logic               is_halt;
   logic               at_last;
   logic [NB_DATA-1:0] word_next;

   // A start pulse is only honoured outside LOAD; bytes only count inside LOAD.
   assign start     = load_start_i && (state != LOAD);
   assign byte_take = (state == LOAD) && rx_done_tick_i;
   assign word_done = byte_take && (byte_cnt == BCW'(BYTES - 1));
   assign word_next = {shift_reg[NB_DATA-N_BITS-1:0], rx_data_i};
   assign is_halt   = (word_next == HALT_WORD);
   assign at_last   = (addr_cnt == {NB_ADDR{1'b1}});

   assign busy_o      = (state == LOAD);
   assign load_done_o = (state == DONE);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: the load ends on the word that is HALT or lands on the last address.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (load_start_i) state_next = LOAD;
         LOAD: if (word_done && (is_halt || at_last)) state_next = DONE;
         DONE: if (load_start_i) state_next = LOAD;
         default: state_next = IDLE;
      endcase
   end

   // Byte assembly, write strobe generation and load bookkeeping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_cnt     <= '0;
         addr_cnt     <= '0;
         shift_reg    <= '0;
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         overflow_o   <= 1'b0;
         word_count_o <= '0;
      end else begin
         wr_en_o <= 1'b0;
         if (start) begin
            byte_cnt     <= '0;
            addr_cnt     <= '0;
            shift_reg    <= '0;
            overflow_o   <= 1'b0;
            word_count_o <= '0;
         end else if (byte_take) begin
            shift_reg <= word_next;
            if (word_done) begin
               byte_cnt     <= '0;
               wr_en_o      <= 1'b1;
               wr_addr_o    <= addr_cnt;
               wr_data_o    <= word_next;
               word_count_o <= word_count_o + 1'b1;
               if (!at_last) begin
                  addr_cnt <= addr_cnt + 1'b1;
               end
               if (at_last && !is_halt) begin
                  overflow_o <= 1'b1;
               end
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized byte streams checked against a word-level
// reference model of the loader.
module tb_instruction_loader;

   localparam logic [31:0] HALT = 32'hFC000000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic        rx_tick = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        load_done;
   logic        overflow;
   logic [7:0]  word_count;

   instruction_loader dut (
      .clock          (clock),
      .reset          (reset),
      .load_start_i   (load_start),
      .rx_data_i      (rx_data),
      .rx_done_tick_i (rx_tick),
      .wr_en_o        (wr_en),
      .wr_addr_o      (wr_addr),
      .wr_data_o      (wr_data),
      .busy_o         (busy),
      .load_done_o    (load_done),
      .overflow_o     (overflow),
      .word_count_o   (word_count)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   int cyc = 0;
   // Cycle counter used to time write strobes against byte ticks.
   always @(posedge clock) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [7:0]  tx_q[$];
   int          tick_cyc[$];
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_tick[$];
   int          exp_count;
   bit          exp_done;
   bit          exp_ovf;
   int          obs_addr[$];
   logic [31:0] obs_data[$];
   int          obs_cyc[$];
   int          dbl = 0;
   logic        prev_wr = 1'b0;

   // Record every write strobe seen between clock edges, plus any strobe that lasts two cycles.
   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         obs_addr.push_back(int'(wr_addr));
         obs_data.push_back(wr_data);
         obs_cyc.push_back(cyc);
         if (prev_wr === 1'b1) dbl++;
      end
      prev_wr = wr_en;
   end

   task clear_obs;
      obs_addr.delete();
      obs_data.delete();
      obs_cyc.delete();
      dbl = 0;
   endtask

   task idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task pulse_start(input bit with_tick, input logic [7:0] b);
      @(negedge clock);
      load_start = 1'b1;
      rx_tick    = with_tick;
      rx_data    = b;
      @(negedge clock);
      load_start = 1'b0;
      rx_tick    = 1'b0;
   endtask

   task drive_bytes(input int max_gap);
      tick_cyc.delete();
      for (int i = 0; i < tx_q.size(); i++) begin
         rx_tick = 1'b0;
         repeat ($urandom_range(0, max_gap)) @(negedge clock);
         rx_data = tx_q[i];
         rx_tick = 1'b1;
         tick_cyc.push_back(cyc);
         @(negedge clock);
      end
      rx_tick = 1'b0;
   endtask

   task add_rand_word;
      tx_q.push_back(8'($urandom_range(0, 8'hFB)));
      repeat (3) tx_q.push_back(8'($urandom));
   endtask

   // Reference: group the bytes received during a load into words, one write per word,
   // stopping after HALT or after the 128th word.
   task model_run;
      logic [31:0] w;
      int          n;
      bit          stop;
      exp_addr.delete();
      exp_data.delete();
      exp_tick.delete();
      exp_count = 0;
      exp_done  = 0;
      exp_ovf   = 0;
      w = 0; n = 0; stop = 0;
      for (int i = 0; i < tx_q.size() && !stop; i++) begin
         w = {w[23:0], tx_q[i]};
         n++;
         if (n == 4) begin
            n = 0;
            exp_addr.push_back(exp_count);
            exp_data.push_back(w);
            exp_tick.push_back(i);
            exp_count++;
            if (w == HALT) begin
               stop = 1; exp_done = 1;
            end else if (exp_count == 128) begin
               stop = 1; exp_done = 1; exp_ovf = 1;
            end
         end
      end
   endtask

   task test_reset;
      reset = 1'b1;
      idle(3);
      n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en); end
      n_cmp++; if (wr_addr !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %h expected 0", wr_addr); end
      n_cmp++; if (wr_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_load_done: got %b expected 0", load_done); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
      n_cmp++; if (word_count !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_word_count: got %0d expected 0", word_count); end
      reset = 1'b0;
      idle(2);
   endtask

   task test_halt_load;
      clear_obs();
      pulse_start(1'b0, 8'h00);
      tx_q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
      model_run();
      drive_bytes(3);
      idle(3);
      n_cmp++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("[TB] FAIL halt_write_count: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
         n_cmp++; if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin n_fail++; $display("[TB] FAIL halt_write[%0d]: got %0d/%h expected %0d/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]); end
      end
      n_cmp++; if (load_done !== exp_done) begin n_fail++; $display("[TB] FAIL halt_load_done: got %b expected %b", load_done, exp_done); end
      n_cmp++; if (overflow !== exp_ovf) begin n_fail++; $display("[TB] FAIL halt_overflow: got %b expected %b", overflow, exp_ovf); end
      n_cmp++; if (word_count !== 8'(exp_count)) begin n_fail++; $display("[TB] FAIL halt_word_count: got %0d expected %0d", word_count, exp_count); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_busy: got %b expected 0", busy); end
   endtask

   task test_reload;
      clear_obs();
      tx_q.delete();
      repeat (6) tx_q.push_back(8'($urandom));
      drive_bytes(1);
      idle(2);
      n_cmp++; if (obs_addr.size() != 0) begin n_fail++; $display("[TB] FAIL done_ignores_bytes: got %0d writes expected 0", obs_addr.size()); end
      n_cmp++; if (word_count !== 8'd2) begin n_fail++; $display("[TB] FAIL done_word_count_hold: got %0d expected 2", word_count); end
      n_cmp++; if (wr_addr !== 7'd1 || wr_data !== HALT) begin n_fail++; $display("[TB] FAIL done_write_hold: got %0d/%h expected 1/%h", wr_addr, wr_data, HALT); end
      clear_obs();
      pulse_start(1'b0, 8'h00);
      n_cmp++; if (load_done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reload_state: got done=%b busy=%b expected done=0 busy=1", load_done, busy); end
      tx_q = '{8'hFC, 8'h00, 8'h00, 8'h00};
      model_run();
      drive_bytes(2);
      idle(3);
      n_cmp++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("[TB] FAIL reload_write_count: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
         n_cmp++; if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin n_fail++; $display("[TB] FAIL reload_write[%0d]: got %0d/%h expected %0d/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]); end
      end
      n_cmp++; if (load_done !== exp_done || overflow !== exp_ovf) begin n_fail++; $display("[TB] FAIL reload_done: got done=%b ovf=%b expected done=%b ovf=%b", load_done, overflow, exp_done, exp_ovf); end
      n_cmp++; if (word_count !== 8'(exp_count)) begin n_fail++; $display("[TB] FAIL reload_word_count: got %0d expected %0d", word_count, exp_count); end
   endtask

   task test_overflow;
      clear_obs();
      pulse_start(1'b0, 8'h00);
      tx_q.delete();
      repeat (520) tx_q.push_back(8'h11);
      model_run();
      drive_bytes(1);
      idle(3);
      n_cmp++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("[TB] FAIL ovf_write_count: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
         n_cmp++; if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin n_fail++; $display("[TB] FAIL ovf_write[%0d]: got %0d/%h expected %0d/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]); end
      end
      n_cmp++; if (load_done !== exp_done || overflow !== exp_ovf) begin n_fail++; $display("[TB] FAIL ovf_done: got done=%b ovf=%b expected done=%b ovf=%b", load_done, overflow, exp_done, exp_ovf); end
      n_cmp++; if (word_count !== 8'(exp_count)) begin n_fail++; $display("[TB] FAIL ovf_word_count: got %0d expected %0d", word_count, exp_count); end
      n_cmp++; if (wr_addr !== 7'd127) begin n_fail++; $display("[TB] FAIL ovf_last_addr: got %0d expected 127", wr_addr); end
   endtask

   task test_back_to_back;
      clear_obs();
      pulse_start(1'b0, 8'h00);
      tx_q.delete();
      repeat (3) add_rand_word();
      model_run();
      drive_bytes(0);
      idle(3);
      n_cmp++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("[TB] FAIL b2b_write_count: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
         n_cmp++; if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin n_fail++; $display("[TB] FAIL b2b_write[%0d]: got %0d/%h expected %0d/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]); end
         n_cmp++; if (obs_cyc[k] !== tick_cyc[exp_tick[k]] + 1) begin n_fail++; $display("[TB] FAIL b2b_latency[%0d]: got cycle %0d expected %0d", k, obs_cyc[k], tick_cyc[exp_tick[k]] + 1); end
      end
      n_cmp++; if (dbl !== 0) begin n_fail++; $display("[TB] FAIL b2b_pulse_width: got %0d long strobes expected 0", dbl); end
      n_cmp++; if (busy !== 1'b1 || load_done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_state: got busy=%b done=%b expected busy=1 done=0", busy, load_done); end
      n_cmp++; if (word_count !== 8'(exp_count)) begin n_fail++; $display("[TB] FAIL b2b_word_count: got %0d expected %0d", word_count, exp_count); end
   endtask

   task test_reset_midload;
      clear_obs();
      tx_q.delete();
      repeat (2) tx_q.push_back(8'($urandom));
      drive_bytes(1);
      reset = 1'b1;
      #1;
      n_cmp++; if (wr_en !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_flags: got wr=%b busy=%b done=%b ovf=%b expected all 0", wr_en, busy, load_done, overflow); end
      n_cmp++; if (wr_addr !== 7'd0 || wr_data !== 32'd0 || word_count !== 8'd0) begin n_fail++; $display("[TB] FAIL midreset_regs: got %0d/%h/%0d expected 0/0/0", wr_addr, wr_data, word_count); end
      idle(2);
      reset = 1'b0;
      idle(2);
      n_cmp++; if (obs_addr.size() != 0) begin n_fail++; $display("[TB] FAIL midreset_no_write: got %0d writes expected 0", obs_addr.size()); end
      clear_obs();
      pulse_start(1'b0, 8'h00);
      tx_q.delete();
      add_rand_word();
      model_run();
      drive_bytes(2);
      idle(3);
      n_cmp++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("[TB] FAIL midreset_write_count: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
         n_cmp++; if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin n_fail++; $display("[TB] FAIL midreset_write[%0d]: got %0d/%h expected %0d/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]); end
      end
      n_cmp++; if (word_count !== 8'(exp_count)) begin n_fail++; $display("[TB] FAIL midreset_word_count: got %0d expected %0d", word_count, exp_count); end
   endtask

   task test_idle_ticks;
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(1);
      clear_obs();
      tx_q.delete();
      repeat (3) tx_q.push_back(8'($urandom));
      drive_bytes(1);
      pulse_start(1'b1, 8'($urandom));
      tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      model_run();
      tx_q = '{8'hAA, 8'hBB};
      drive_bytes(1);
      pulse_start(1'b0, 8'h00);
      tx_q = '{8'hCC, 8'hDD};
      drive_bytes(1);
      idle(3);
      n_cmp++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("[TB] FAIL idle_write_count: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
         n_cmp++; if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin n_fail++; $display("[TB] FAIL idle_write[%0d]: got %0d/%h expected %0d/%h", k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]); end
      end
      n_cmp++; if (busy !== 1'b1 || word_count !== 8'(exp_count)) begin n_fail++; $display("[TB] FAIL idle_state: got busy=%b count=%0d expected busy=1 count=%0d", busy, word_count, exp_count); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      $display("[TB] instruction_loader bench start");
      test_reset();
      test_halt_load();
      test_reload();
      test_overflow();
      test_back_to_back();
      test_reset_midload();
      test_idle_ticks();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
